ccip_host_responder: RTL and testbench

- Host-side endpoint model for CCI-P. Sits on the upstream side of the sub-AFU mux, in place of the FIU.
- Consumes Tx requests (c0 reads, c1 writes) and returns Rx responses from a small line-addressed backing memory, with programmable latency and injectable congestion.
- Gives the mux buffer a self-contained bench and simulation partner with real flow control (c0/c1 almost-full).

---
 rtl/ccip_host_responder.sv | 228 ++++++++++++++++++++++
 tb/tb_ccip_host_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccip_host_responder.sv
// Host-side CCI-P endpoint: answers c0 reads / c1 writes from a line-addressed backing memory.
// Latency: c0 response exactly >= RD_LATENCY, c1 >= WR_LATENCY cycles after acceptance, registered.
// Backpressure: per-channel pending FIFOs with almost-full; host_stall holds all responses. Optional HOST_RSP_STATS_EN.

package ccip_if_pkg;
  typedef logic [1:0]   t_ccip_vc;
  typedef logic [1:0]   t_ccip_clLen;
  typedef logic [3:0]   t_ccip_c0_req;
  typedef logic [3:0]   t_ccip_c1_req;
  typedef logic [3:0]   t_ccip_c0_rsp;
  typedef logic [3:0]   t_ccip_c1_rsp;
  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [15:0]  t_ccip_mdata;
  typedef logic [511:0] t_ccip_clData;

  localparam t_ccip_vc     eVC_VA = 2'd0, eVC_VL0 = 2'd1, eVC_VH0 = 2'd2, eVC_VH1 = 2'd3;
  localparam t_ccip_clLen  eCL_LEN_1 = 2'd0, eCL_LEN_2 = 2'd1, eCL_LEN_4 = 2'd3;
  localparam t_ccip_c0_req eREQ_RDLINE_I = 4'h0, eREQ_RDLINE_S = 4'h1;
  localparam t_ccip_c1_req eREQ_WRLINE_I = 4'h0, eREQ_WRLINE_M = 4'h1, eREQ_WRPUSH_I = 4'h2,
                           eREQ_WRFENCE = 4'h4, eREQ_INTR = 4'h6;
  localparam t_ccip_c0_rsp eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4;
  localparam t_ccip_c1_rsp eRSP_WRLINE = 4'h0, eRSP_WRFENCE = 4'h4, eRSP_INTR = 4'h6;

  typedef struct packed {
    t_ccip_vc vc_sel; logic [1:0] rsvd1; t_ccip_clLen cl_len; t_ccip_c0_req req_type;
    logic [5:0] rsvd0; t_ccip_clAddr address; t_ccip_mdata mdata;
  } t_ccip_c0_ReqMemHdr;
  typedef struct packed {
    logic [5:0] rsvd2; t_ccip_vc vc_sel; logic sop; logic rsvd1; t_ccip_clLen cl_len;
    t_ccip_c1_req req_type; logic [5:0] rsvd0; t_ccip_clAddr address; t_ccip_mdata mdata;
  } t_ccip_c1_ReqMemHdr;
  typedef struct packed { logic [8:0] tid; } t_ccip_c2_RspMmioHdr;
  typedef struct packed {
    t_ccip_vc vc_used; logic rsvd1; logic hit_miss; logic [1:0] rsvd0;
    logic [1:0] cl_num; t_ccip_c0_rsp resp_type; t_ccip_mdata mdata;
  } t_ccip_c0_RspMemHdr;
  typedef struct packed {
    t_ccip_vc vc_used; logic rsvd1; logic hit_miss; logic format; logic rsvd0;
    logic [1:0] cl_num; t_ccip_c1_rsp resp_type; t_ccip_mdata mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed { t_ccip_c0_ReqMemHdr hdr; logic valid; } t_if_ccip_c0_Tx;
  typedef struct packed { t_ccip_c1_ReqMemHdr hdr; t_ccip_clData data; logic valid; } t_if_ccip_c1_Tx;
  typedef struct packed { t_ccip_c2_RspMmioHdr hdr; logic mmioRdValid; logic [63:0] data; } t_if_ccip_c2_Tx;
  typedef struct packed { t_if_ccip_c0_Tx c0; t_if_ccip_c1_Tx c1; t_if_ccip_c2_Tx c2; } t_if_ccip_Tx;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr; t_ccip_clData data; logic rspValid; logic mmioRdValid; logic mmioWrValid;
  } t_if_ccip_c0_Rx;
  typedef struct packed { t_ccip_c1_RspMemHdr hdr; logic rspValid; } t_if_ccip_c1_Rx;
  typedef struct packed {
    logic c0TxAlmFull; logic c1TxAlmFull; t_if_ccip_c0_Rx c0; t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;
endpackage

// Generic synchronous FIFO with combinational head and occupancy count.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the caller must not push when full nor pop when empty.
module host_rsp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   pClk,
  input  logic                   SoftReset_n,
  input  logic                   push,
  input  logic [W-1:0]           pushDat,
  input  logic                   pop,
  output logic [W-1:0]           headDat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] store [DEPTH];
  logic [AW:0]  wrPtr, rdPtr;

  // Storage is never reset; only the pointers define validity.
  always_ff @(posedge pClk) begin
    if (push) store[wrPtr[AW-1:0]] <= pushDat;
  end

  // Pointer update; extra MSB distinguishes full from empty.
  always_ff @(posedge pClk) begin
    if (!SoftReset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  assign headDat = store[rdPtr[AW-1:0]];
  assign count   = wrPtr - rdPtr;
endmodule

module ccip_host_responder
  import ccip_if_pkg::*;
#(
  parameter int MEM_LINES     = 256,
  parameter int DEPTH         = 16,
  parameter int ALMFULL_SLACK = 4,
  parameter int RD_LATENCY    = 8,
  parameter int WR_LATENCY    = 4
) (
  input  logic        pClk,
  input  logic        SoftReset_n,
  input  t_if_ccip_Tx up_TxPort,
  output t_if_ccip_Rx up_RxPort,
  input  logic        host_stall,
  output logic        err_overflow,
  output logic        err_badreq
`ifdef HOST_RSP_STATS_EN
  ,
  output logic [31:0] stat_rd_cnt,
  output logic [31:0] stat_wr_cnt,
  output logic [31:0] stat_stall_cyc
`endif
);
  localparam int IW = $clog2(MEM_LINES);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] ALM_LVL  = CW'(DEPTH - ALMFULL_SLACK);

  typedef struct packed { t_ccip_clData data; t_ccip_mdata mdata; logic [15:0] due; } t_rdEntry;
  typedef struct packed { t_ccip_mdata mdata; logic [15:0] due; } t_wrEntry;

  t_ccip_clData  mem [MEM_LINES];
  logic [15:0]   cycleCnt, rdSlack, wrSlack;
  t_rdEntry      rdHead, rdPush;
  t_wrEntry      wrHead, wrPush;
  logic [CW-1:0] rdCount, wrCount, rdNext, wrNext;
  logic [IW-1:0] c0Idx, c1Idx;
  logic          c0Good, c1Good, rdFull, wrFull, c0Acc, c1Acc;
  logic          rdDue, wrDue, rdPop, wrPop;
  logic          unusedTx;

  // c2 and reserved/upper address bits carry nothing this model needs.
  assign unusedTx = ^up_TxPort;

  assign c0Idx  = up_TxPort.c0.hdr.address[IW-1:0];
  assign c1Idx  = up_TxPort.c1.hdr.address[IW-1:0];
  assign c0Good = (up_TxPort.c0.hdr.cl_len == eCL_LEN_1) &&
                  (up_TxPort.c0.hdr.req_type == eREQ_RDLINE_I || up_TxPort.c0.hdr.req_type == eREQ_RDLINE_S);
  assign c1Good = up_TxPort.c1.hdr.sop && (up_TxPort.c1.hdr.cl_len == eCL_LEN_1) &&
                  (up_TxPort.c1.hdr.req_type == eREQ_WRLINE_I || up_TxPort.c1.hdr.req_type == eREQ_WRLINE_M);

  // Fullness ignores a same-cycle pop: a push at full is always an overflow.
  assign rdFull = (rdCount == FULL_LVL);
  assign wrFull = (wrCount == FULL_LVL);
  assign c0Acc  = SoftReset_n && up_TxPort.c0.valid && c0Good && !rdFull;
  assign c1Acc  = SoftReset_n && up_TxPort.c1.valid && c1Good && !wrFull;

  // The read data is captured at acceptance, so a same-cycle write to that line is not seen.
  assign rdPush = '{data: mem[c0Idx], mdata: up_TxPort.c0.hdr.mdata, due: cycleCnt + 16'(RD_LATENCY)};
  assign wrPush = '{mdata: up_TxPort.c1.hdr.mdata, due: cycleCnt + 16'(WR_LATENCY)};

  // Signed distance past the due time keeps the test correct across counter wrap.
  assign rdSlack = cycleCnt - rdHead.due;
  assign wrSlack = cycleCnt - wrHead.due;
  assign rdDue   = (rdCount != '0) && !rdSlack[15];
  assign wrDue   = (wrCount != '0) && !wrSlack[15];
  assign rdPop   = SoftReset_n && rdDue && !host_stall;
  assign wrPop   = SoftReset_n && wrDue && !host_stall;

  assign rdNext = rdCount + CW'(c0Acc) - CW'(rdPop);
  assign wrNext = wrCount + CW'(c1Acc) - CW'(wrPop);

  host_rsp_fifo #(.W($bits(t_rdEntry)), .DEPTH(DEPTH)) rdFifo (
    .pClk(pClk), .SoftReset_n(SoftReset_n), .push(c0Acc), .pushDat(rdPush),
    .pop(rdPop), .headDat(rdHead), .count(rdCount)
  );
  host_rsp_fifo #(.W($bits(t_wrEntry)), .DEPTH(DEPTH)) wrFifo (
    .pClk(pClk), .SoftReset_n(SoftReset_n), .push(c1Acc), .pushDat(wrPush),
    .pop(wrPop), .headDat(wrHead), .count(wrCount)
  );

  // Backing memory write; contents deliberately survive reset.
  always_ff @(posedge pClk) begin
    if (c1Acc) mem[c1Idx] <= up_TxPort.c1.data;
  end

  // Cycle counter, registered responses, almost-full and sticky errors.
  always_ff @(posedge pClk) begin
    if (!SoftReset_n) begin
      cycleCnt     <= '0;
      up_RxPort    <= '0;
      err_overflow <= 1'b0;
      err_badreq   <= 1'b0;
    end else begin
      cycleCnt              <= cycleCnt + 16'd1;
      up_RxPort             <= '0;
      up_RxPort.c0TxAlmFull <= (rdNext >= ALM_LVL);
      up_RxPort.c1TxAlmFull <= (wrNext >= ALM_LVL);
      if (rdPop) begin
        up_RxPort.c0.rspValid      <= 1'b1;
        up_RxPort.c0.hdr.vc_used   <= eVC_VH0;
        up_RxPort.c0.hdr.resp_type <= eRSP_RDLINE;
        up_RxPort.c0.hdr.mdata     <= rdHead.mdata;
        up_RxPort.c0.data          <= rdHead.data;
      end
      if (wrPop) begin
        up_RxPort.c1.rspValid      <= 1'b1;
        up_RxPort.c1.hdr.resp_type <= eRSP_WRLINE;
        up_RxPort.c1.hdr.mdata     <= wrHead.mdata;
      end
      if ((up_TxPort.c0.valid && !c0Good) || (up_TxPort.c1.valid && !c1Good))
        err_badreq <= 1'b1;
      if ((up_TxPort.c0.valid && rdFull) || (up_TxPort.c1.valid && wrFull))
        err_overflow <= 1'b1;
    end
  end

`ifdef HOST_RSP_STATS_EN
  // Saturating activity counters; stall cycles count only when something was ready to go.
  always_ff @(posedge pClk) begin
    if (!SoftReset_n) begin
      stat_rd_cnt    <= '0;
      stat_wr_cnt    <= '0;
      stat_stall_cyc <= '0;
    end else begin
      if (c0Acc && stat_rd_cnt != '1) stat_rd_cnt <= stat_rd_cnt + 32'd1;
      if (c1Acc && stat_wr_cnt != '1) stat_wr_cnt <= stat_wr_cnt + 32'd1;
      if (host_stall && (rdDue || wrDue) && stat_stall_cyc != '1)
        stat_stall_cyc <= stat_stall_cyc + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ccip_host_responder.sv
// Randomized and directed stimulus against a queue-based model of the host responder.
module tb_ccip_host_responder;
  import ccip_if_pkg::*;

  localparam int DEPTH = 16;
  localparam int RDL   = 8;
  localparam int WRL   = 4;
  localparam int ML    = 256;

  logic        pClk = 1'b0;
  logic        SoftReset_n;
  t_if_ccip_Tx tx;
  t_if_ccip_Rx rx;
  logic        host_stall;
  logic        errOv, errBad;
`ifdef HOST_RSP_STATS_EN
  logic [31:0] sRd, sWr, sStallC;
`endif

  always #5 pClk = ~pClk;

  ccip_host_responder dut (
    .pClk(pClk), .SoftReset_n(SoftReset_n), .up_TxPort(tx), .up_RxPort(rx),
    .host_stall(host_stall), .err_overflow(errOv), .err_badreq(errBad)
`ifdef HOST_RSP_STATS_EN
    , .stat_rd_cnt(sRd), .stat_wr_cnt(sWr), .stat_stall_cyc(sStallC)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [15:0] mdata; logic [511:0] data; longint due; } t_pend;
  t_pend        rdQ[$], wrQ[$];
  logic [511:0] mMem [ML];
  longint       now = 0;
  bit           mErrOv = 0, mErrBad = 0;

  // Observation log for directed latency/data checks.
  int           edgeCnt = 0;
  int           c0Rsps = 0, c1Rsps = 0, lastC0Edge = 0, lastC1Edge = 0;
  logic [15:0]  lastC0Md, lastC1Md;
  logic [511:0] lastC0Dat;
  logic [15:0]  c0MdLog[$];

  function automatic bit c0Bad(t_if_ccip_c0_Tx c);
    return !(c.hdr.cl_len == eCL_LEN_1 && (c.hdr.req_type == eREQ_RDLINE_I || c.hdr.req_type == eREQ_RDLINE_S));
  endfunction
  function automatic bit c1Bad(t_if_ccip_c1_Tx c);
    return !(c.hdr.sop && c.hdr.cl_len == eCL_LEN_1 &&
             (c.hdr.req_type == eREQ_WRLINE_I || c.hdr.req_type == eREQ_WRLINE_M));
  endfunction

  // Single compare process: advance the model with the inputs seen at each edge, then check outputs.
  initial begin
    t_if_ccip_Tx        sTx;
    logic               sRst, sStall;
    bit                 e0v, e1v, rdFull, wrFull;
    t_pend              e0, e1, p;
    t_ccip_c0_RspMemHdr h0;
    t_ccip_c1_RspMemHdr h1;
    forever begin
      @(posedge pClk);
      edgeCnt++;
      sTx = tx; sRst = SoftReset_n; sStall = host_stall;
      e0v = 0; e1v = 0;
      if (!sRst) begin
        rdQ.delete(); wrQ.delete();
        now = 0; mErrOv = 0; mErrBad = 0;
      end else begin
        rdFull = (rdQ.size() == DEPTH);
        wrFull = (wrQ.size() == DEPTH);
        if (!sStall && rdQ.size() > 0 && now >= rdQ[0].due) begin e0v = 1; e0 = rdQ.pop_front(); end
        if (!sStall && wrQ.size() > 0 && now >= wrQ[0].due) begin e1v = 1; e1 = wrQ.pop_front(); end
        if (sTx.c0.valid) begin
          if (c0Bad(sTx.c0)) mErrBad = 1;
          if (rdFull) mErrOv = 1;
          else if (!c0Bad(sTx.c0)) begin
            p.mdata = sTx.c0.hdr.mdata; p.data = mMem[sTx.c0.hdr.address % ML]; p.due = now + RDL;
            rdQ.push_back(p);
          end
        end
        if (sTx.c1.valid) begin
          if (c1Bad(sTx.c1)) mErrBad = 1;
          if (wrFull) mErrOv = 1;
          else if (!c1Bad(sTx.c1)) begin
            mMem[sTx.c1.hdr.address % ML] = sTx.c1.data;
            p.mdata = sTx.c1.hdr.mdata; p.data = '0; p.due = now + WRL;
            wrQ.push_back(p);
          end
        end
        now++;
      end
      #1;
      check("c0_valid", rx.c0.rspValid, e0v);
      check("c1_valid", rx.c1.rspValid, e1v);
      check("alm0", rx.c0TxAlmFull, sRst && rdQ.size() >= DEPTH - 4);
      check("alm1", rx.c1TxAlmFull, sRst && wrQ.size() >= DEPTH - 4);
      check("err_ov", errOv, mErrOv);
      check("err_bad", errBad, mErrBad);
      check("mmio", {rx.c0.mmioRdValid, rx.c0.mmioWrValid}, 2'b00);
      if (e0v) begin
        h0 = '0; h0.vc_used = eVC_VH0; h0.resp_type = eRSP_RDLINE; h0.mdata = e0.mdata;
        check("c0_hdr", rx.c0.hdr, h0);
        check("c0_data", rx.c0.data, e0.data);
      end
      if (e1v) begin
        h1 = '0; h1.resp_type = eRSP_WRLINE; h1.mdata = e1.mdata;
        check("c1_hdr", rx.c1.hdr, h1);
      end
      if (rx.c0.rspValid === 1'b1) begin
        c0Rsps++; lastC0Edge = edgeCnt; lastC0Md = rx.c0.hdr.mdata; lastC0Dat = rx.c0.data;
        c0MdLog.push_back(rx.c0.hdr.mdata);
      end
      if (rx.c1.rspValid === 1'b1) begin
        c1Rsps++; lastC1Edge = edgeCnt; lastC1Md = rx.c1.hdr.mdata;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic t_if_ccip_c0_Tx mkRd(logic [41:0] a, logic [15:0] md);
    t_if_ccip_c0_Tx c = '0;
    c.hdr.address = a; c.hdr.mdata = md; c.hdr.req_type = eREQ_RDLINE_I;
    c.hdr.cl_len = eCL_LEN_1; c.valid = 1'b1;
    return c;
  endfunction
  function automatic t_if_ccip_c1_Tx mkWr(logic [41:0] a, logic [15:0] md, logic [511:0] d);
    t_if_ccip_c1_Tx c = '0;
    c.hdr.address = a; c.hdr.mdata = md; c.hdr.req_type = eREQ_WRLINE_I;
    c.hdr.cl_len = eCL_LEN_1; c.hdr.sop = 1'b1; c.data = d; c.valid = 1'b1;
    return c;
  endfunction
  function automatic logic [511:0] rndLine();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction
  task automatic step(input int n = 1);
    repeat (n) @(negedge pClk);
  endtask
  task automatic doReset();
    SoftReset_n = 1'b0; tx.c0.valid = 1'b0; tx.c1.valid = 1'b0;
    step();
    SoftReset_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int acc0, acc1, n0;
    logic [511:0] lineA, lineX, lineY;
    lineA = {16{32'hA5A5_0001}};
    lineX = {16{32'h1111_0003}};
    lineY = {16{32'h2222_0003}};
    SoftReset_n = 1'b0; host_stall = 1'b0; tx = '0;
    step(2);
    check("rst_rsp", {rx.c0.rspValid, rx.c1.rspValid, rx.c0TxAlmFull, rx.c1TxAlmFull}, 4'b0);
    check("rst_err", {errOv, errBad}, 2'b0);
    SoftReset_n = 1'b1;

    // Give every line a defined value.
    for (int i = 0; i < ML; i++) begin
      tx.c1 = mkWr({34'($urandom), 8'(i)}, 16'(i), rndLine());
      step();
    end
    tx.c1.valid = 1'b0;
    step(10);

    // Write then read, exact latencies.
    tx.c1 = mkWr(42'h5, 16'h11, lineA); step(); acc1 = edgeCnt; tx.c1.valid = 1'b0;
    tx.c0 = mkRd(42'h5, 16'h22); step(); acc0 = edgeCnt; tx.c0.valid = 1'b0;
    step(12);
    check("wr_lat", 32'(lastC1Edge - acc1), 32'd4);
    check("wr_md", lastC1Md, 16'h11);
    check("rd_lat", 32'(lastC0Edge - acc0), 32'd8);
    check("rd_md", lastC0Md, 16'h22);
    check("rd_dat", lastC0Dat, lineA);

    // Same-cycle read/write collision.
    tx.c1 = mkWr(42'h3, 16'h30, lineX); step(); tx.c1.valid = 1'b0; step(8);
    tx.c0 = mkRd(42'h3, 16'h31); tx.c1 = mkWr(42'h3, 16'h32, lineY); step();
    tx.c0.valid = 1'b0; tx.c1.valid = 1'b0; step(12);
    check("coll_old", lastC0Dat, lineX);
    tx.c0 = mkRd(42'h3, 16'h33); step(); tx.c0.valid = 1'b0; step(12);
    check("coll_new", lastC0Dat, lineY);
    check("coll_md", lastC0Md, 16'h33);

    // Back-pressure, almost-full and overflow.
    host_stall = 1'b1;
    n0 = c0Rsps;
    for (int i = 0; i < 16; i++) begin
      tx.c0 = mkRd(42'(i), 16'(i)); step();
      if (i == 10) check("alm_at11", rx.c0TxAlmFull, 1'b0);
      if (i == 11) check("alm_at12", rx.c0TxAlmFull, 1'b1);
    end
    check("ov_before", errOv, 1'b0);
    tx.c0 = mkRd(42'h10, 16'h10); step(); tx.c0.valid = 1'b0;
    check("ov_after", errOv, 1'b1);
    c0MdLog.delete();
    step(3); host_stall = 1'b0; step(40);
    check("bp_count", 32'(c0Rsps - n0), 32'd16);
    for (int i = 0; i < 16; i++) check("bp_order", c0MdLog[i], 16'(i));
    doReset();

    // Bad request is neither queued nor answered.
    n0 = c0Rsps;
    tx.c0 = mkRd(42'h7, 16'h55); tx.c0.hdr.cl_len = eCL_LEN_4; step(); tx.c0.valid = 1'b0;
    step(20);
    check("bad_err", errBad, 1'b1);
    check("bad_norsp", 32'(c0Rsps - n0), 32'd0);
    check("bad_noov", errOv, 1'b0);
    doReset();

    // Reset with reads in flight.
    for (int i = 0; i < 5; i++) begin tx.c0 = mkRd(42'h5, 16'h60 + 16'(i)); step(); end
    tx.c0.valid = 1'b0;
    n0 = c0Rsps;
    doReset();
    step(30);
    check("rstf_norsp", 32'(c0Rsps - n0), 32'd0);
    check("rstf_alm", {rx.c0TxAlmFull, rx.c1TxAlmFull}, 2'b00);
    tx.c0 = mkRd(42'h5, 16'h70); step(); tx.c0.valid = 1'b0; step(12);
    check("rstf_mem", lastC0Dat, lineA);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      host_stall = ($urandom_range(0, 3) == 0);
      tx.c0.valid = 1'b0; tx.c1.valid = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        tx.c0 = mkRd({10'($urandom_range(0, 1023)), 32'($urandom)}, 16'($urandom));
        tx.c0.hdr.req_type = ($urandom_range(0, 1) == 1) ? eREQ_RDLINE_S : eREQ_RDLINE_I;
        if ($urandom_range(0, 63) == 0) tx.c0.hdr.cl_len = 2'($urandom_range(1, 3));
      end
      if ($urandom_range(0, 1) == 1) begin
        tx.c1 = mkWr({10'($urandom_range(0, 1023)), 32'($urandom)}, 16'($urandom), rndLine());
        tx.c1.hdr.req_type = ($urandom_range(0, 1) == 1) ? eREQ_WRLINE_M : eREQ_WRLINE_I;
        if ($urandom_range(0, 63) == 0) tx.c1.hdr.req_type = eREQ_WRFENCE;
      end
      step();
    end
    tx.c0.valid = 1'b0; tx.c1.valid = 1'b0; host_stall = 1'b0;
    step(60);

    // Counter wrap: the read is accepted with the internal counter at 0xFFFC.
    doReset();
    step(16'hFFFC);
    tx.c0 = mkRd(42'h5, 16'h80); step(); acc0 = edgeCnt; tx.c0.valid = 1'b0;
    step(12);
    check("wrap_lat", 32'(lastC0Edge - acc0), 32'd8);
    check("wrap_md", lastC0Md, 16'h80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
